// File: rtl/cpu_pkg.sv
// Shared opcode, ALU operation, class and state definitions for the control unit.
// Imported by instr_class_decode and control_unit.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b1001;
  localparam logic [3:0] ALU_OR  = 4'b1010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_RR, C_ALU_IMM, C_LDI, C_LD,
    C_ST, C_MULDIV, C_UNARY, C_MFHI,
    C_MFLO, C_NOP, C_HALT
  } iclass_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       hi_out;
    logic       lo_out;
    logic       mdr_out;
    logic       c_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       hi_in;
    logic       lo_in;
    logic       zin_high;
    logic       zin_low;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic [3:0] op;
    logic       run;
  } ctrl_t;

  // Final timing state of each instruction class.
  function automatic state_e last_state(iclass_e c);
    unique case (c)
      C_ALU_RR, C_ALU_IMM, C_LDI: last_state = S_T5;
      C_LD, C_ST:                 last_state = S_T7;
      C_MULDIV:                   last_state = S_T6;
      C_UNARY:                    last_state = S_T4;
      default:                    last_state = S_T3;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode-to-class decode.
// in: opcode[4:0]; out: iclass, imm_op (ALU op for immediate forms).
import cpu_pkg::*;

module instr_class_decode (
  input  logic [4:0] opcode,
  output iclass_e    iclass,
  output logic [3:0] imm_op
);

  always_comb begin
    iclass = C_NOP;
    imm_op = ALU_ADD;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:
        iclass = C_ALU_RR;
      OP_ADDI: iclass = C_ALU_IMM;
      OP_ANDI: begin
        iclass = C_ALU_IMM;
        imm_op = ALU_AND;
      end
      OP_ORI: begin
        iclass = C_ALU_IMM;
        imm_op = ALU_OR;
      end
      OP_LDI:          iclass = C_LDI;
      OP_LD:           iclass = C_LD;
      OP_ST:           iclass = C_ST;
      OP_MUL, OP_DIV:  iclass = C_MULDIV;
      OP_NEG, OP_NOT:  iclass = C_UNARY;
      OP_MFHI:         iclass = C_MFHI;
      OP_MFLO:         iclass = C_MFLO;
      OP_HALT:         iclass = C_HALT;
      default:         iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch T0-T2, class sequence from T3, HALT and RESET.
// in: Clock, clear, IR, Stop; out: datapath strobes, operation, Run.
import cpu_pkg::*;

module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        HIin,
  output logic        LOin,
  output logic        Zin_high,
  output logic        Zin_low,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  operation,
  output logic        Run
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [3:0] imm_op;
  logic [4:0] opcode;
  ctrl_t      ctrl, ctrl_o;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  instr_class_decode u_dec (
    .opcode (opcode),
    .iclass (iclass),
    .imm_op (imm_op)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      default: begin
        if (state_q == S_T3 && iclass == C_HALT)
          state_d = S_HALT;
        else if (state_q == last_state(iclass))
          state_d = S_T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
    // Stop only takes effect at an instruction boundary.
    if (state_d == S_T0 && Stop)
      state_d = S_HALT;
  end

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        ctrl.pc_out  = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.zin_low = 1'b1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (iclass)
          C_ALU_RR, C_ALU_IMM: begin
            ctrl.grb  = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.y_in = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          C_MULDIV: begin
            ctrl.gra  = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.y_in = 1'b1;
          end
          C_UNARY: begin
            ctrl.grb     = 1'b1;
            ctrl.rout    = 1'b1;
            ctrl.zin_low = 1'b1;
            ctrl.op      = opcode[3:0];
          end
          C_MFHI: begin
            ctrl.hi_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.rin    = 1'b1;
          end
          C_MFLO: begin
            ctrl.lo_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.rin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (iclass)
          C_ALU_RR: begin
            ctrl.grc     = 1'b1;
            ctrl.rout    = 1'b1;
            ctrl.zin_low = 1'b1;
            ctrl.op      = opcode[3:0];
          end
          C_ALU_IMM: begin
            ctrl.c_out   = 1'b1;
            ctrl.zin_low = 1'b1;
            ctrl.op      = imm_op;
          end
          C_LDI, C_LD, C_ST: begin
            ctrl.c_out   = 1'b1;
            ctrl.zin_low = 1'b1;
            ctrl.op      = ALU_ADD;
          end
          C_MULDIV: begin
            ctrl.grb      = 1'b1;
            ctrl.rout     = 1'b1;
            ctrl.zin_low  = 1'b1;
            ctrl.zin_high = 1'b1;
            ctrl.op       = opcode[3:0];
          end
          C_UNARY: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.rin      = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (iclass)
          C_ALU_RR, C_ALU_IMM, C_LDI: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.rin      = 1'b1;
          end
          C_LD, C_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
          end
          C_MULDIV: begin
            ctrl.zlow_out = 1'b1;
            ctrl.lo_in    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (iclass)
          C_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          C_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          C_MULDIV: begin
            ctrl.zhigh_out = 1'b1;
            ctrl.hi_in     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (iclass)
          C_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.rin     = 1'b1;
          end
          C_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Outputs drop the instant clear rises, not at the next edge.
  assign ctrl_o = clear ? '0 : ctrl;

  assign PCout     = ctrl_o.pc_out;
  assign Zlowout   = ctrl_o.zlow_out;
  assign Zhighout  = ctrl_o.zhigh_out;
  assign HIout     = ctrl_o.hi_out;
  assign LOout     = ctrl_o.lo_out;
  assign MDRout    = ctrl_o.mdr_out;
  assign Cout      = ctrl_o.c_out;
  assign MARin     = ctrl_o.mar_in;
  assign PCin      = ctrl_o.pc_in;
  assign MDRin     = ctrl_o.mdr_in;
  assign IRin      = ctrl_o.ir_in;
  assign Yin       = ctrl_o.y_in;
  assign IncPC     = ctrl_o.inc_pc;
  assign Read      = ctrl_o.read;
  assign Write     = ctrl_o.write;
  assign HIin      = ctrl_o.hi_in;
  assign LOin      = ctrl_o.lo_in;
  assign Zin_high  = ctrl_o.zin_high;
  assign Zin_low   = ctrl_o.zin_low;
  assign Gra       = ctrl_o.gra;
  assign Grb       = ctrl_o.grb;
  assign Grc       = ctrl_o.grc;
  assign Rin       = ctrl_o.rin;
  assign Rout      = ctrl_o.rout;
  assign BAout     = ctrl_o.ba_out;
  assign operation = ctrl_o.op;
  assign Run       = ctrl_o.run;

endmodule
